// File: rtl/debouncer_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package debouncer_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int unsigned DB_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  import debouncer_pkg::*;

  logic [DB_SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[DB_SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[DB_SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: clean level plus a one-cycle tick per debounced press.
// Define DB_SYNC_EN to place a two-flop synchronizer ahead of the FSM.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic db_level,
  output logic db_tick
);
  import debouncer_pkg::*;

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

`ifdef DB_SYNC_EN
  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_in),
    .q       (s)
  );
`else
  assign s = btn_in;
`endif

  // Candidate states count down a full stability window; any contrary sample aborts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ZERO;
      cnt      <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      db_tick <= 1'b0;
      case (state)
        ZERO: begin
          if (s) begin
            state <= WAIT1;
            cnt   <= CNT_LOAD;
          end
        end
        WAIT1: begin
          if (!s) begin
            state <= ZERO;
          end else if (cnt == '0) begin
            state    <= ONE;
            db_level <= 1'b1;
            db_tick  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ONE: begin
          if (!s) begin
            state <= WAIT0;
            cnt   <= CNT_LOAD;
          end
        end
        WAIT0: begin
          if (s) begin
            state <= ONE;
          end else if (cnt == '0) begin
            state    <= ZERO;
            db_level <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state    <= ZERO;
          db_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;
  import debouncer_pkg::*;

  localparam int SC = 4;
`ifdef DB_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int SIDX = (SYNC > 0) ? SYNC - 1 : 0;
  localparam int LAT  = SC + SYNC + 1;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic btn_in   = 1'b0;
  logic db_level;
  logic db_tick;

  int checks = 0;
  int errors = 0;

  button_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_in),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  always #5 clk = ~clk;

  // Reference: level flips once the FSM input has disagreed with it for SC+1 samples in a row.
  logic [2:0] pipe    = '0;
  logic       s_m     = 1'b0;
  logic       m_level = 1'b0;
  logic       m_tick  = 1'b0;
  int         run     = 0;
  int         m_ticks = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe    = '0;
      run     = 0;
      m_level = 1'b0;
      m_tick  = 1'b0;
    end else begin
      s_m    = (SYNC == 0) ? btn_in : pipe[SIDX];
      pipe   = {pipe[1:0], btn_in};
      m_tick = 1'b0;
      if (s_m != m_level) begin
        run++;
        if (run == SC + 1) begin
          m_level = s_m;
          m_tick  = s_m;
          run     = 0;
          if (s_m) m_ticks++;
        end
      end else begin
        run = 0;
      end
    end
  end

  // Downstream 4-bit up counter enabled by the tick, plus a raw tick tally.
  logic [3:0] cnt_q = '0;
  int         tick_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (db_tick) cnt_q <= cnt_q + 4'd1;
  end

  always @(negedge clk) if (db_tick === 1'b1) tick_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: compare outputs with the model at the falling edge, then apply the next input.
  task automatic drive(input logic b);
    @(negedge clk);
    check("level", 32'(db_level), 32'(m_level));
    check("tick", 32'(db_tick), 32'(m_tick));
    btn_in = b;
  endtask

  task automatic wait_level(input string tag, input logic b, input int exp_edges);
    int n;
    n = 0;
    do begin
      drive(b);
      n++;
    end while (db_level !== b && n < 40);
    check(tag, 32'(n), 32'(exp_edges));
    check({tag, "_tick"}, 32'(db_tick), 32'(b));
  endtask

  task automatic hold_until(input string tag, input logic b);
    drive(b);
    wait_level(tag, b, LAT);
  endtask

  task automatic idle(input logic b, input int n);
    for (int i = 0; i < n; i++) drive(b);
  endtask

  int t0;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(db_level), 32'd0);
    check("rst_tick", 32'(db_tick), 32'd0);
    check("rst_state", 32'(dut.state), 32'(ZERO));
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b0, 5);

    // Clean press, then release: level follows after LAT edges, single tick, none on release
    t0 = tick_cnt;
    hold_until("press_lat", 1'b1);
    idle(1'b1, 10);
    check("press_ticks", 32'(tick_cnt - t0), 32'd1);
    hold_until("release_lat", 1'b0);
    idle(1'b0, 10);
    check("release_ticks", 32'(tick_cnt - t0), 32'd1);

    // Bounce shorter than the window is rejected
    t0 = tick_cnt;
    idle(1'b1, 3); idle(1'b0, 1); idle(1'b1, 2); idle(1'b0, 8);
    check("bounce_ticks", 32'(tick_cnt - t0), 32'd0);
    check("bounce_level", 32'(db_level), 32'd0);
    check("bounce_state", 32'(dut.state), 32'(ZERO));

    // Release bounce from ONE keeps the level high without a new tick
    hold_until("press2_lat", 1'b1);
    idle(1'b1, 8);
    t0 = tick_cnt;
    idle(1'b0, 2); idle(1'b1, 10);
    check("relbounce_level", 32'(db_level), 32'd1);
    check("relbounce_ticks", 32'(tick_cnt - t0), 32'd0);

    // Reset during WAIT0 clears the high level immediately
    drive(1'b0);
    idle(1'b0, SYNC + 1);
    check("in_wait0", 32'(dut.state), 32'(WAIT0));
    #2 reset_n = 1'b0;
    #1;
    check("rst0_level", 32'(db_level), 32'd0);
    check("rst0_state", 32'(dut.state), 32'(ZERO));
    btn_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    t0 = tick_cnt;
    wait_level("rst_press_lat", 1'b1, LAT);
    idle(1'b1, 4);
    check("rst_press_ticks", 32'(tick_cnt - t0), 32'd1);

    // Reset during WAIT1 clears state and counter immediately
    hold_until("release2_lat", 1'b0);
    idle(1'b0, 3);
    drive(1'b1);
    idle(1'b1, SYNC + 1);
    check("in_wait1", 32'(dut.state), 32'(WAIT1));
    #2 reset_n = 1'b0;
    #1;
    check("rst1_state", 32'(dut.state), 32'(ZERO));
    check("rst1_cnt", 32'(dut.cnt), 32'd0);
    check("rst1_tick", 32'(db_tick), 32'd0);
    btn_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b0, 4);

    // Three clean presses advance the downstream counter by three
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      hold_until("cnt_press", 1'b1);
      idle(1'b1, 3);
      hold_until("cnt_release", 1'b0);
      idle(1'b0, 3);
    end
    check("counter_q", 32'(cnt_q), 32'd3);

    // Random bouncing segments, compared against the model every cycle
    for (int seg = 0; seg < 80; seg++) begin
      logic lv;
      int   len;
      lv  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 2 * SC + 3));
      idle(lv, len);
    end
    idle(1'b0, LAT + 2);
    check("total_ticks", 32'(tick_cnt), 32'(m_ticks));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces one raw pushbutton or switch input. Produces a clean level `db_level` and a single-cycle rising-edge pulse `db_tick`. Sits directly upstream of the 4-bit synchronous up counter: `db_tick` drives the counter's count enable, so one physical press advances the count by exactly one.

## Interface
- `STABLE_CYCLES`, default 2_000_000 (20 ms at 100 MHz): consecutive cycles the input must hold a new value before the output follows; legal range ≥1.
- `CNT_W`, default `$clog2(STABLE_CYCLES)` with a minimum of 1: width of the internal stability counter; derived, never overridden.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `btn_in`  input  1  raw, bouncing, asynchronous button input.
- `db_level`  output  1  debounced level, registered.
- `db_tick`  output  1  one-cycle pulse on each debounced 0→1 transition, registered.

## Operation
- Four-state FSM:
  - ZERO: stable low.
  - WAIT1: candidate high.
  - ONE: stable high.
  - WAIT0: candidate low.
- FSM input `s`:
  - With the synchronizer compiled in, `s` is the synchronized `btn_in`.
  - Without it, `s` is `btn_in` directly.
- ZERO:
  - `s`=1 → WAIT1, load `cnt` with STABLE_CYCLES−1.
  - Otherwise stay.
- WAIT1:
  - `s`=0 → ZERO; this is a glitch, so no tick.
  - Else if `cnt`==0 → ONE, assert `db_tick` for exactly the first cycle in ONE.
  - Else decrement `cnt`.
- ONE:
  - `s`=0 → WAIT0, load `cnt` with STABLE_CYCLES−1.
  - Otherwise stay.
- WAIT0:
  - `s`=1 → ONE; no tick is generated on this re-entry.
  - Else if `cnt`==0 → ZERO.
  - Else decrement `cnt`.
- `db_level` = 1 in ONE and WAIT0, 0 in ZERO and WAIT1. It is registered alongside the state, so it has no glitches.
- No tick is ever produced on a falling transition.
- `cnt` saturates at 0. It never wraps, and it never decrements in ZERO or ONE.
- Reset (`reset_n`=0, any time, including mid-WAIT1 or mid-WAIT0):
  - state = ZERO, `cnt` = 0, synchronizer flops = 0, `db_level` = 0, `db_tick` = 0, all immediately.
- `btn_in` held high across reset release: treated as a fresh press. It runs through WAIT1 and produces one tick.

## Timing
- Latency with the synchronizer: `btn_in` rises before edge t and stays high → WAIT1 at edge t+2 → `db_level`=1 and `db_tick`=1 from edge t+STABLE_CYCLES+2. `db_tick` falls at the next edge.
- Latency without the synchronizer: same sequence shifted two cycles earlier; `db_level` rises at edge t+STABLE_CYCLES.
- Falling edge: same latency as the rising edge, and `db_tick` stays 0.
- Minimum accepted pulse width: STABLE_CYCLES+1 sampled-high cycles at the FSM input. Anything shorter is rejected.
- STABLE_CYCLES=1: WAIT1 lasts exactly one cycle.
- Ticks are separated by at least 2·(STABLE_CYCLES+1) cycles.

## Configuration
- `DB_SYNC_EN`:
  - Defined: a 2-flop synchronizer sits between `btn_in` and the FSM. This adds 2 cycles of latency and is mandatory for board builds.
  - Undefined: `btn_in` feeds the FSM directly. This is for simulation with a synchronous stimulus only; all latencies above drop by 2.

## Structure
- Package `debouncer_pkg`:
  - state enum `db_state_t` (ZERO, WAIT1, ONE, WAIT0), 2-bit encoding.
  - localparam `DB_SYNC_STAGES` = 2.
- Sub-module `sync_2ff`: generic two-flop synchronizer with `clk`, `reset_n`, `d`, `q`, reset value 0. It is instantiated only under `DB_SYNC_EN`.
- Top level: FSM next-state logic, `cnt` register, registered outputs.

## Test plan
All scenarios use STABLE_CYCLES=4, T=10 ns and `DB_SYNC_EN` defined; t is the edge before which `btn_in` changes.
- Clean press: `btn_in` 0→1 before edge 10 and held → `db_level`=1 and `db_tick`=1 at edge 16; `db_tick`=0 at edge 17; exactly one tick in total.
- Bounce rejection: `btn_in` high for 3 cycles, low 1, high 2, low → `db_level` stays 0, zero ticks, FSM returns to ZERO.
- Release: from stable high, `btn_in`=0 before edge 30 → `db_level`=0 at edge 36, no tick.
- Release bounce: from ONE, `btn_in` low 2 cycles then high → `db_level` stays 1, no tick.
- Reset mid-operation: `reset_n`=0 while in WAIT1 → outputs and state go to 0/ZERO at once, without waiting for a clock edge. After release with `btn_in` held high → one tick 6 cycles later.
- Counter integration: 3 clean presses drive the downstream up counter's enable → counter Q = 4'd3.
- Variant without `DB_SYNC_EN`: repeat the clean-press scenario → tick at edge 14.
